// File: rtl/infoframe_scheduler.sv
// Round-robin InfoFrame scheduler: per-source pending bits, snapshot holding registers, valid/accept offer.
// Optional macro INFOFRAME_CHECKSUM_EN adds a SUM state that rewrites PB0 with the InfoFrame checksum.
module infoframe_scheduler #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic                         clk_pixel,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [NUM_SRC-1:0]           src_enable,
  input  logic [NUM_SRC-1:0]           src_update,
  input  logic [NUM_SRC*24-1:0]        src_header,
  input  logic [NUM_SRC*224-1:0]       src_sub,
  output logic                         packet_valid,
  input  logic                         packet_accept,
  output logic [23:0]                  header,
  output logic [3:0][55:0]             sub,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic [7:0]                   overrun_count
);

  localparam int unsigned GW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SUM, S_OFFER} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic [23:0]        hdr_q, hdr_d;
  logic [3:0][55:0]   sub_q, sub_d;
  logic               valid_q, valid_d;
  logic [7:0]         ovr_q, ovr_d;

  logic               found;
  logic [GW-1:0]      pick;
  int unsigned        idx;

`ifdef INFOFRAME_CHECKSUM_EN
  logic [7:0]         csum;
  logic [223:0]       sub_flat;
  assign sub_flat = sub_q;
`endif

  // First pending source searching upward from last_grant+1, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(last_q) + k) % NUM_SRC;
      if (!found && pending_q[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    grant_d   = grant_q;
    last_d    = last_q;
    hdr_d     = hdr_q;
    sub_d     = sub_q;
    ovr_d     = ovr_q;
`ifdef INFOFRAME_CHECKSUM_EN
    csum      = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
          if (grant_q == GW'(i)) begin
            hdr_d = src_header[i*24 +: 24];
            sub_d = src_sub[i*224 +: 224];
          end
        end
`ifdef INFOFRAME_CHECKSUM_EN
        state_d = S_SUM;
`else
        state_d = S_OFFER;
`endif
      end
      S_SUM: begin
`ifdef INFOFRAME_CHECKSUM_EN
        // PB j sits at flat byte j, so PB1..PB27 are bytes 1..27.
        csum = hdr_q[7:0] + hdr_q[15:8] + hdr_q[23:16];
        for (int j = 1; j < 28; j++) csum = csum + sub_flat[j*8 +: 8];
        sub_d[0][7:0] = 8'h00 - csum;
        state_d = S_OFFER;
`else
        state_d = S_IDLE;
`endif
      end
      S_OFFER: begin
        if (packet_accept) begin
          pending_d[grant_q] = 1'b0;
          last_d             = grant_q;
          state_d            = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disabled sources drop their request unless already in flight; sets are applied last so they win.
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!src_enable[i] && !(state_q != S_IDLE && grant_q == GW'(i))) pending_d[i] = 1'b0;
      if (src_enable[i] && (frame_start || src_update[i])) pending_d[i] = 1'b1;
    end

    if (frame_start && (|(pending_q & src_enable)) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

    valid_d = (state_d == S_OFFER);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      last_q    <= GW'(NUM_SRC - 1);
      hdr_q     <= '0;
      sub_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      hdr_q     <= hdr_d;
      sub_q     <= sub_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign packet_valid  = valid_q;
  assign header        = hdr_q;
  assign sub           = sub_q;
  assign grant_id      = grant_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_infoframe_scheduler.sv
// Self-checking bench for infoframe_scheduler (NUM_SRC=4): vector table, scoreboard of offered packets, corner sequences.
module tb_infoframe_scheduler;

`ifdef INFOFRAME_CHECKSUM_EN
  localparam int       LAT     = 3;
  localparam bit [7:0] EXP_PB0 = 8'h5F;
`else
  localparam int       LAT     = 2;
  localparam bit [7:0] EXP_PB0 = 8'h00;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_start;
  logic [3:0]      src_enable;
  logic [3:0]      src_update;
  logic [95:0]     src_header;
  logic [895:0]    src_sub;
  logic            packet_valid;
  logic            packet_accept;
  logic [23:0]     header;
  logic [3:0][55:0] sub_o;
  logic [1:0]      grant_id;
  logic [7:0]      overrun_count;

  logic [23:0]     hdr_tb [4];
  logic [223:0]    sub_tb [4];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]   gid;
    logic [23:0]  hdr;
    logic [223:0] sub;
  } pkt_t;

  typedef struct packed {
    logic [3:0]      ena;
    logic [3:0]      upd;
    logic            fs;
    logic [2:0]      n;
    logic [3:0][1:0] order;
  } vec_t;

  pkt_t sb[$];
  vec_t vecs [7];

  infoframe_scheduler #(.NUM_SRC(4)) dut (
    .clk_pixel    (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .src_enable   (src_enable),
    .src_update   (src_update),
    .src_header   (src_header),
    .src_sub      (src_sub),
    .packet_valid (packet_valid),
    .packet_accept(packet_accept),
    .header       (header),
    .sub          (sub_o),
    .grant_id     (grant_id),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_header[i*24 +: 24]   = hdr_tb[i];
      src_sub[i*224 +: 224]    = sub_tb[i];
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Expected offered packet for source s from the bench's own copy of the source image.
  function automatic pkt_t model(input int s);
    pkt_t p;
    logic [7:0] sum;
    p.gid = 2'(s);
    p.hdr = hdr_tb[s];
    p.sub = sub_tb[s];
    sum   = 8'h00;
`ifdef INFOFRAME_CHECKSUM_EN
    sum = p.hdr[7:0] + p.hdr[15:8] + p.hdr[23:16];
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 7; b++)
        if (k != 0 || b != 0) sum = sum + p.sub[k*56 + b*8 +: 8];
    p.sub[7:0] = 8'h00 - sum;
`endif
    return p;
  endfunction

  function automatic vec_t mk(input logic [3:0] ena, input logic [3:0] upd, input logic fs,
                              input int n, input int o0, input int o1, input int o2, input int o3);
    vec_t v;
    v.ena = ena; v.upd = upd; v.fs = fs; v.n = 3'(n);
    v.order[0] = 2'(o0); v.order[1] = 2'(o1); v.order[2] = 2'(o2); v.order[3] = 2'(o3);
    return v;
  endfunction

  // Scoreboard: compare the offered packet on every accept.
  always @(negedge clk) begin
    if (!reset && packet_valid && packet_accept) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow got=grant%0d want=no_packet", grant_id);
      end else begin
        pkt_t e;
        e = sb.pop_front();
        chk("sb_gid", 256'(grant_id), 256'(e.gid));
        chk("sb_hdr", 256'(header), 256'(e.hdr));
        chk("sb_sub", 256'(sub_o), 256'(e.sub));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic fs, input logic [3:0] upd);
    frame_start = fs;
    src_update  = upd;
    cyc(1);
    frame_start = 1'b0;
    src_update  = '0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!packet_valid && n < 20) begin
      cyc(1);
      n++;
    end
    chk({nm, "_lat"}, 256'(n), 256'(LAT));
  endtask

  task automatic accept_now(input string nm);
    packet_accept = 1'b1;
    cyc(1);
    packet_accept = 1'b0;
    chk({nm, "_gap"}, 256'(packet_valid), 256'(0));
  endtask

  task automatic serve(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      wait_valid(nm);
      accept_now(nm);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    pkt_t old;
    int   v;
    reset = 1'b1; frame_start = 1'b0; src_enable = '0; src_update = '0; packet_accept = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hdr_tb[i] = {8'h0D, 8'h02, 8'(8'h81 + i)};
      sub_tb[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    end
    vecs[0] = mk(4'hF, 4'h0, 1'b1, 4, 0, 1, 2, 3);
    vecs[1] = mk(4'hF, 4'h0, 1'b1, 4, 0, 1, 2, 3);
    vecs[2] = mk(4'hF, 4'h4, 1'b0, 1, 2, 0, 0, 0);
    vecs[3] = mk(4'hA, 4'h0, 1'b1, 2, 3, 1, 0, 0);
    vecs[4] = mk(4'hF, 4'h9, 1'b0, 2, 3, 0, 0, 0);
    vecs[5] = mk(4'h6, 4'h9, 1'b1, 2, 1, 2, 0, 0);
    vecs[6] = mk(4'h0, 4'h0, 1'b1, 0, 0, 0, 0, 0);

    cyc(3);
    chk("rst_valid", 256'(packet_valid), 256'(0));
    chk("rst_hdr", 256'(header), 256'(0));
    chk("rst_sub", 256'(sub_o), 256'(0));
    chk("rst_gid", 256'(grant_id), 256'(0));
    chk("rst_ovr", 256'(overrun_count), 256'(0));
    reset = 1'b0;
    cyc(1);

    // Single source, known checksum.
    hdr_tb[0] = 24'h0D0282;
    sub_tb[0] = '0;
    sub_tb[0][15:8] = 8'h10;
    src_enable = 4'b0001;
    sb.push_back(model(0));
    pulse(1'b1, 4'h0);
    wait_valid("single");
    chk("single_hdr", 256'(header), 256'(24'h0D0282));
    chk("single_pb0", 256'(sub_o[0][7:0]), 256'(EXP_PB0));
    chk("single_pb1", 256'(sub_o[0][15:8]), 256'(8'h10));
    accept_now("single");
    v = 0;
    repeat (12) begin cyc(1); if (packet_valid) v++; end
    chk("single_no_resend", 256'(v), 256'(0));

    // Vector table: round-robin order across enable/update/frame patterns.
    do_reset();
    for (int r = 0; r < 7; r++) begin
      src_enable  = vecs[r].ena;
      for (int k = 0; k < int'(vecs[r].n); k++) sb.push_back(model(int'(vecs[r].order[k])));
      pulse(vecs[r].fs, vecs[r].upd);
      if (vecs[r].n == 3'd0) begin
        v = 0;
        repeat (8) begin cyc(1); if (packet_valid) v++; end
        chk($sformatf("rr%0d_idle", r), 256'(v), 256'(0));
      end else begin
        serve(int'(vecs[r].n), $sformatf("rr%0d", r));
      end
    end

    // Snapshot stability while held in offer.
    src_enable = 4'b0010;
    sb.push_back(model(1));
    pulse(1'b0, 4'b0010);
    wait_valid("snap");
    old = model(1);
    sub_tb[1] = ~sub_tb[1];
    cyc(10);
    chk("snap_sub", 256'(sub_o), 256'(old.sub));
    chk("snap_valid", 256'(packet_valid), 256'(1));
    accept_now("snap");
    sb.push_back(model(1));
    pulse(1'b0, 4'b0010);
    serve(1, "snap_new");

    // frame_start coincides with the accept of source 1.
    src_enable = 4'hF;
    sb.push_back(model(2)); sb.push_back(model(3)); sb.push_back(model(0)); sb.push_back(model(1));
    pulse(1'b1, 4'h0);
    serve(3, "col");
    wait_valid("col4");
    chk("col_gid", 256'(grant_id), 256'(1));
    sb.push_back(model(2)); sb.push_back(model(3)); sb.push_back(model(0)); sb.push_back(model(1));
    frame_start = 1'b1;
    packet_accept = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    packet_accept = 1'b0;
    chk("col_gap", 256'(packet_valid), 256'(0));
    chk("col_ovr", 256'(overrun_count), 256'(1));
    serve(4, "col_re");

    // Overrun with a stalled picker, then saturation.
    do_reset();
    src_enable = 4'b0100;
    pulse(1'b1, 4'h0);
    wait_valid("ovr");
    pulse(1'b1, 4'h0); cyc(3);
    pulse(1'b1, 4'h0); cyc(3);
    chk("ovr_count2", 256'(overrun_count), 256'(2));
    chk("ovr_valid", 256'(packet_valid), 256'(1));
    chk("ovr_gid", 256'(grant_id), 256'(2));
    for (int p = 4; p <= 255; p++) pulse(1'b1, 4'h0);
    chk("ovr_254", 256'(overrun_count), 256'(254));
    pulse(1'b1, 4'h0);
    chk("ovr_255", 256'(overrun_count), 256'(255));
    repeat (4) pulse(1'b1, 4'h0);
    chk("ovr_sat", 256'(overrun_count), 256'(255));

    // Asynchronous reset while offering.
    #3;
    reset = 1'b1;
    #1;
    chk("arst_valid", 256'(packet_valid), 256'(0));
    chk("arst_ovr", 256'(overrun_count), 256'(0));
    chk("arst_hdr", 256'(header), 256'(0));
    chk("arst_gid", 256'(grant_id), 256'(0));
    cyc(2);
    reset = 1'b0;
    v = 0;
    repeat (10) begin cyc(1); if (packet_valid) v++; end
    chk("arst_no_resume", 256'(v), 256'(0));
    src_enable = 4'hF;
    sb.push_back(model(0)); sb.push_back(model(1)); sb.push_back(model(2)); sb.push_back(model(3));
    pulse(1'b1, 4'h0);
    serve(4, "post_rst");

    cyc(2);
    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/infoframe_scheduler.md
# infoframe_scheduler

Schedules InfoFrame transmission for the HDMI data-island path. It holds up to NUM_SRC InfoFrame sources (AVI, audio, SPD, vendor-specific and similar), each providing a static header/subpacket image. Every enabled source is marked pending at each frame start and whenever its content changes. Pending sources are granted round-robin, and a snapshot of the granted packet is offered to the packet picker under a valid/accept handshake.

## Interface
Parameters:
- NUM_SRC, 4: number of InfoFrame sources, 2..8.

Ports:
- clk_pixel  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of each video frame.
- src_enable  in  NUM_SRC  per-source enable; level.
- src_update  in  NUM_SRC  per-source one-cycle pulse, "content changed".
- src_header  in  NUM_SRC*24  source i header at [i*24 +: 24] = {HB2, HB1, HB0}.
- src_sub  in  NUM_SRC*224  source i at [i*224 +: 224]; subpacket k at [k*56 +: 56], bytes PB(7k)..PB(7k+6), with the low byte first.
- packet_valid  out  1  offered packet is valid.
- packet_accept  in  1  picker latched the offered packet; only meaningful while packet_valid is high.
- header  out  24  offered header.
- sub  out  56 x [3:0]  offered subpackets, same byte order as src_sub.
- grant_id  out  $clog2(NUM_SRC)  index of the source being offered.
- overrun_count  out  8  saturating count of frames where an enabled source was still pending.

## Operation
- pending[i] (internal):
  - Set on frame_start when src_enable[i] is high.
  - Set on src_update[i] when src_enable[i] is high.
  - Cleared on the accept of source i.
  - If set and clear occur in the same cycle, set wins.
  - pending[i] is also cleared when src_enable[i] is low; this does not apply to a source already in LOAD/SUM/OFFER.
- overrun_count increments by 1 on frame_start when any enabled source already has pending set. It increments once per frame regardless of how many sources overran, and saturates at 255.
- FSM states and transitions:
  - IDLE: if any pending bit is set, grant the first pending index searching upward from last_grant+1 mod NUM_SRC, then go to LOAD. Otherwise stay in IDLE.
  - LOAD: capture src_header and src_sub of the granted source into holding registers. Go to SUM if the checksum feature is compiled in, otherwise go to OFFER.
  - SUM: overwrite PB0 of the holding register with the checksum (see Configuration). Go to OFFER.
  - OFFER: packet_valid=1. On packet_accept, clear pending[grant], set last_grant=grant, and go to IDLE.
- The holding registers are the only drivers of header and sub. Changes on the src_* buses never alter a packet already being offered.
- A src_enable drop during LOAD/SUM/OFFER does not abort the packet; it completes normally.

## Timing
- Reset values:
  - packet_valid=0, header=0, sub=0, grant_id=0, overrun_count=0.
  - pending=0, last_grant=NUM_SRC-1, so the first grant is source 0.
  - FSM in IDLE.
- Latency: a pending bit registered at edge E0 leads to packet_valid high after E2 without the checksum feature, or after E3 with it.
- Back-to-back: after the accept edge the FSM is in IDLE, so the next packet_valid follows 2 cycles later (3 with checksum). packet_valid is low for at least 1 cycle between packets.
- packet_valid, header, sub and grant_id stay stable from the start of OFFER until the accept edge.
- Reset asserted mid-operation returns every register to its reset value immediately. No packet is resumed after reset.

## Configuration
- INFOFRAME_CHECKSUM_EN:
  - Defined: the SUM state exists and PB0 = (0 - (HB0+HB1+HB2+PB1+...+PB27)) mod 256. In the offered packet, all 31 bytes sum to 0 mod 256. Latency is 3 cycles.
  - Undefined: there is no SUM state, PB0 is passed unchanged from the source, and latency is 2 cycles.

## Test plan
- Single source with checksum: source 0 header 24'h0D0282, PB1=8'h10, all other PB=0, frame_start pulse. Required: packet_valid high 3 cycles later, PB0=8'h5F, header 24'h0D0282. Then accept, and packet_valid drops with no resend until the next frame_start.
- Round-robin: all 4 sources enabled, frame_start, immediate accept each time. Required: grant_id sequence 0,1,2,3; the next frame continues 0,1,2,3 from last_grant.
- Snapshot stability: change src_sub of the granted source while in OFFER with accept held low for 10 cycles. Required: sub unchanged; after accept, src_update causes the new content to be sent.
- Overrun: source 2 enabled, accept never asserted, 3 frame_start pulses. Required: overrun_count=2 and packet_valid still high on source 2. Also run past 255 frames and check the count saturates at 255.
- Set/clear collision: frame_start coincides with the accept of source 1. Required: source 1 is pending again and re-offered after the other pending sources in round-robin order.
- Reset mid-OFFER: assert reset while packet_valid=1. Required: packet_valid=0, pending=0 and overrun_count=0 asynchronously. After release, the next frame_start grants source 0 first.
